ita_softmax_div_sched: RTL
==========================

# ita_softmax_div_sched

Scheduler between the softmax division FIFO and the bank of `NUM_DIV` serial dividers. Dispatches dividends round-robin, retires quotients strictly in dispatch order, and arbitrates the single accumulator write port against the stream-softmax datapath. Sequential quotient addresses are generated per row group, with a `row_done_o` pulse after every `ROWS` results.

## Interface

Parameters:
- `NUM_DIV`, default 4: number of dividers. Must be ≥2.
- `DATA_W`, default 32: dividend width (softmax accumulator width).
- `OUT_W`, default 32: quotient width.
- `ROWS`, default 64: results per row group (M).
- `ADDR_W`, default `$clog2(ROWS)`: write address width.

Ports:
- `clk_i` in, 1: single clock.
- `rst_ni` in, 1: asynchronous, active-low reset.
- `flush_i` in, 1: synchronous clear of all state.
- `req_valid_i` in, 1: FIFO not empty.
- `req_data_i` in, `DATA_W`: FIFO head dividend.
- `req_ready_o` out, 1: pop FIFO.
- `div_valid_o` out, `NUM_DIV`: one-hot dispatch valid.
- `div_ready_i` in, `NUM_DIV`: divider idle.
- `div_data_o` out, `DATA_W`: broadcast dividend, equal to `req_data_i`.
- `div_valid_i` in, `NUM_DIV`: quotient valid.
- `div_data_i` in, `NUM_DIV`×`OUT_W`: quotients.
- `div_ready_o` out, `NUM_DIV`: one-hot quotient accept.
- `acc_busy_i` in, 1: accumulator write port claimed by stream softmax this cycle.
- `wr_en_o` out, 1: accumulator write.
- `wr_addr_o` out, `ADDR_W`: write address.
- `wr_data_o` out, `OUT_W`: write data.
- `row_done_o` out, 1: one-cycle pulse on the last write of a row group.
- `inflight_o` out, `$clog2(NUM_DIV+1)`: dispatched but not yet retired.
- `busy_o` out, 1: `inflight_o != 0` or `wr_en_o`.

## Operation

State:
- Dispatch pointer `rd_ptr` and retire pointer `wr_ptr`, each in 0..`NUM_DIV`-1. Each wraps to 0 after `NUM_DIV`-1.
- `inflight` counter, range 0..`NUM_DIV`.
- Address counter `addr`, range 0..`ROWS`-1.

Dispatch (combinational):
- `can_disp = inflight < NUM_DIV`.
- `div_valid_o[rd_ptr] = req_valid_i & can_disp`. All other bits are 0.
- `req_ready_o = div_ready_i[rd_ptr] & can_disp`. This must not depend on `req_valid_i`.
- Dispatch fire = `req_valid_i & req_ready_o`. On fire, `rd_ptr` advances.

Retire (combinational):
- `div_ready_o[wr_ptr] = !acc_busy_i & (inflight != 0)`. All other bits are 0.
- Quotients presented by non-head dividers wait; they are never accepted out of order.
- Retire fire = `div_valid_i[wr_ptr] & div_ready_o[wr_ptr]`. On fire:
  - `wr_ptr` advances.
  - `div_data_i[wr_ptr]` is registered into `wr_data_o`.
  - `addr` is registered into `wr_addr_o`.
  - `addr` increments.

Counter updates:
- `inflight` +1 on dispatch only, −1 on retire only, unchanged when both fire.
- When `addr == ROWS-1` retires, `addr` wraps to 0 and `row_done_o` is asserted together with that write.

Flush and reset:
- `flush_i` clears pointers, `inflight`, `addr`, `wr_en_o` and `row_done_o` next cycle. Flush has priority over same-cycle fires.
- The dividers are flushed externally in the same cycle.

## Timing

- Reset values: `wr_en_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `row_done_o`=0, `inflight_o`=0, `busy_o`=0, `div_valid_o`=0, `div_ready_o`=0.
- `req_ready_o` equals `div_ready_i[0]` during reset.
- Dispatch is a zero-latency pass-through of `req_data_i` to `div_data_o`.
- Retire-to-write latency is 1 cycle. `wr_en_o` is high exactly one cycle per retire fire.
- Back-to-back retires write on consecutive cycles.
- `acc_busy_i` high: no retire that cycle. Results held by dividers are unaffected.
- `inflight == NUM_DIV`: `req_ready_o`=0 and `div_valid_o`=0 regardless of `div_ready_i`.
- `inflight == 0`: `div_ready_o`=0, even if `div_valid_i` is asserted.
- Async reset mid-operation: all state cleared immediately. In-flight quotients are lost.

## Test plan

- **Single dividend.** After reset, `req_valid_i`=1, data 0x100, all `div_ready_i`=1 → `div_valid_o`=0001 and `req_ready_o`=1 in the same cycle. When divider 0 returns 0x7F, `wr_en_o`=1 one cycle later with `wr_addr_o`=0 and `wr_data_o`=0x7F.
- **Saturation.** Issue 5 dividends with no results returned → 4 dispatched to dividers 0,1,2,3, `inflight_o`=4, fifth held with `req_ready_o`=0. Retiring divider 0 lets the fifth go to divider 0 the next cycle.
- **Out-of-order completion.** Divider 2 is valid before divider 0 → no write while 0 is pending. After divider 0 completes, writes occur to addresses 0,1,2 in order.
- **Arbitration.** Hold `acc_busy_i`=1 for 3 cycles while divider 0 is valid → no `wr_en_o` for 3 cycles. The write occurs one cycle after release.
- **Row wrap.** Retire 64 results → `row_done_o` pulses once, together with `wr_addr_o`=63. The 65th write goes to address 0.
- **Flush.** Assert `flush_i` with `inflight`=3 and a simultaneous retire fire → next cycle `inflight_o`=0, `wr_en_o`=0, pointers and `addr` are 0.

Source files
------------

// File: rtl/ita_softmax_div_sched.sv
// Softmax divider scheduler: round-robin dispatch to NUM_DIV serial dividers,
// strictly in-order retirement, and accumulator write-port arbitration.
module ita_softmax_div_sched #(
    parameter int NUM_DIV  = 4,
    parameter int DATA_W   = 32,
    parameter int OUT_W    = 32,
    parameter int ROWS     = 64,
    parameter int ADDR_W   = $clog2(ROWS),
    localparam int PTR_W   = $clog2(NUM_DIV),
    localparam int CNT_W   = $clog2(NUM_DIV + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     req_valid_i,
    input  logic [DATA_W-1:0]        req_data_i,
    output logic                     req_ready_o,
    output logic [NUM_DIV-1:0]       div_valid_o,
    input  logic [NUM_DIV-1:0]       div_ready_i,
    output logic [DATA_W-1:0]        div_data_o,
    input  logic [NUM_DIV-1:0]       div_valid_i,
    input  logic [NUM_DIV*OUT_W-1:0] div_data_i,
    output logic [NUM_DIV-1:0]       div_ready_o,
    input  logic                     acc_busy_i,
    output logic                     wr_en_o,
    output logic [ADDR_W-1:0]        wr_addr_o,
    output logic [OUT_W-1:0]         wr_data_o,
    output logic                     row_done_o,
    output logic [CNT_W-1:0]         inflight_o,
    output logic                     busy_o
);

    localparam logic [CNT_W-1:0]  INFL_MAX  = CNT_W'(NUM_DIV);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NUM_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ROWS - 1);

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  inflight;
    logic [ADDR_W-1:0] addr;

    logic              can_disp;
    logic              can_retire;
    logic              rd_sel_ready;
    logic              head_valid;
    logic [OUT_W-1:0]  head_data;
    logic              disp_fire;
    logic              ret_fire;

    assign can_disp   = inflight < INFL_MAX;
    assign can_retire = !acc_busy_i && (inflight != '0);

    // Select the divider addressed by each pointer without variable-width indexing.
    always_comb begin
        rd_sel_ready = 1'b0;
        head_valid   = 1'b0;
        head_data    = '0;
        div_valid_o  = '0;
        div_ready_o  = '0;
        for (int i = 0; i < NUM_DIV; i++) begin
            if (PTR_W'(i) == rd_ptr) begin
                rd_sel_ready   = div_ready_i[i];
                div_valid_o[i] = req_valid_i & can_disp;
            end
            if (PTR_W'(i) == wr_ptr) begin
                head_valid     = div_valid_i[i];
                head_data      = div_data_i[i*OUT_W +: OUT_W];
                div_ready_o[i] = can_retire;
            end
        end
    end

    // Ready is independent of req_valid_i so the FIFO pop handshake stays loop-free.
    assign req_ready_o = rd_sel_ready & can_disp;
    assign div_data_o  = req_data_i;
    assign disp_fire   = req_valid_i & req_ready_o;
    assign ret_fire    = head_valid & can_retire;

    assign inflight_o  = inflight;
    assign busy_o      = (inflight != '0) || wr_en_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            inflight   <= '0;
            addr       <= '0;
            wr_en_o    <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            row_done_o <= 1'b0;
        end else if (flush_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            inflight   <= '0;
            addr       <= '0;
            wr_en_o    <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            row_done_o <= 1'b0;
        end else begin
            wr_en_o    <= ret_fire;
            row_done_o <= ret_fire && (addr == ADDR_LAST);

            if (disp_fire) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end

            if (ret_fire) begin
                wr_ptr    <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
                wr_data_o <= head_data;
                wr_addr_o <= addr;
                addr      <= (addr == ADDR_LAST) ? '0 : addr + 1'b1;
            end

            case ({disp_fire, ret_fire})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule
